frame_buffer_arbiter: RTL

- Shares the single-port frame-buffer SRAM between the three GPU draw engines: line drawer (BLA, id 0), fill (id 1) and alpha blend (id 2).
- Round-robin arbitration with burst locking and a per-owner burst cap.
- A fixed-latency read-return pipeline steers each read's data back to the requester that issued it.
- Sits between the engines and the SRAM interface; the main controller uses busy to know when the frame buffer is quiescent.

---
 rtl/gpu_pkg.sv | 31 +++
 rtl/rd_tag_pipe.sv | 48 ++++
 rtl/frame_buffer_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: requester ids, frame-buffer arbiter state encoding,
// read-return tag format, frame dimensions and the round-robin step helper.
package gpu_pkg;

   localparam int unsigned NUM_REQ   = 3;
   localparam int unsigned FB_WIDTH  = 640;
   localparam int unsigned FB_HEIGHT = 480;

   typedef enum logic [1:0] {
      REQ_BLA   = 2'd0,
      REQ_FILL  = 2'd1,
      REQ_ALPHA = 2'd2
   } req_id_e;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_e;

   // One entry of the read-return pipeline: which requester a read belongs to.
   typedef struct packed {
      logic       valid;
      logic [1:0] id;
   } rd_tag_t;

   // Next requester id in round-robin order, wrapping after the last engine.
   function automatic logic [1:0] rr_next(input logic [1:0] id);
      return (id >= 2'(NUM_REQ - 1)) ? 2'd0 : id + 2'd1;
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, id} tags for outstanding SRAM
// reads, so returning data can be steered to the engine that issued it.
//   clk_i      : clock
//   rst_i      : asynchronous reset, active-high; drops every tag in flight
//   push_i     : tag entering this cycle (valid=0 for writes and idle cycles)
//   pop_o      : tag leaving the tail, aligned with SRAM read data
//   nonempty_o : at least one valid tag anywhere in the pipeline
import gpu_pkg::*;

module rd_tag_pipe #(
   parameter int unsigned RD_LAT = 2
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  rd_tag_t push_i,
   output rd_tag_t pop_o,
   output logic    nonempty_o
);

   rd_tag_t [RD_LAT-1:0] pipe_q;
   rd_tag_t [RD_LAT-1:0] pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = push_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   always_comb begin
      nonempty_o = 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         nonempty_o = nonempty_o | pipe_q[i].valid;
      end
   end

   assign pop_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Shares the single-port frame-buffer SRAM between the line drawer (0), fill (1)
// and alpha blend (2) engines. Round-robin arbitration with burst locking and a
// per-owner burst cap; read data is steered back through a tag pipeline.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   req_i/we_i     : per-engine request and write enable, held until granted
//   addr_i/wdata_i : per-engine address / write data, engine i at slice i
//   gnt_o          : one-hot, access accepted this cycle
//   rvalid_o       : one-hot, read data for engine i valid this cycle
//   rdata_o        : shared read data (SRAM data while a return is valid)
//   mem_*_o        : SRAM strobe, write enable, address, write data
//   mem_rdata_i    : SRAM read data, valid RD_LAT cycles after a read strobe
//   busy_o         : an owner is active or a read is still in flight
import gpu_pkg::*;

module frame_buffer_arbiter #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 24,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        rvalid_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      mem_en_o,
   output logic                      mem_we_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic [DATA_W-1:0]         mem_rdata_i,
   output logic                      busy_o
);

   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BurstLast = CNT_W'(MAX_BURST - 1);

   arb_state_e       state_q, state_d;
   req_id_e          owner_q, owner_d;
   req_id_e          last_owner_q, last_owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   logic [1:0]       cand;
   logic             found;
   req_id_e          sel;
   logic             others_req;

   rd_tag_t          rd_push;
   rd_tag_t          rd_pop;
   logic             rd_nonempty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         owner_q      <= REQ_BLA;
         last_owner_q <= REQ_ALPHA;  // so the line drawer wins the first round
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   assign others_req = |(req_i & ~(NUM_REQ'(1) << owner_q));

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      gnt_o        = '0;
      mem_en_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      cand         = rr_next(last_owner_q);
      found        = 1'b0;
      sel          = owner_q;

      case (state_q)
         IDLE: begin
            // Arbitration cycle only: no SRAM access until the owner is registered.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
               if (!found && req_i[cand]) begin
                  sel   = req_id_e'(cand);
                  found = 1'b1;
               end
               cand = rr_next(cand);
            end
            if (found) begin
               owner_d     = sel;
               burst_cnt_d = '0;
               state_d     = OWN;
            end
         end
         OWN: begin
            if (req_i[owner_q]) begin
               gnt_o[owner_q] = 1'b1;
               mem_en_o       = 1'b1;
               mem_we_o       = we_i[owner_q];
               mem_addr_o     = addr_i[owner_q*ADDR_W +: ADDR_W];
               mem_wdata_o    = wdata_i[owner_q*DATA_W +: DATA_W];
               burst_cnt_d    = burst_cnt_q + CNT_W'(1);
               if (burst_cnt_q == BurstLast) begin
                  // Cap only forces a hand-over when someone else is waiting.
                  burst_cnt_d = '0;
                  if (others_req) begin
                     state_d      = IDLE;
                     last_owner_d = owner_q;
                  end
               end
            end else begin
               state_d      = IDLE;
               last_owner_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_push       = '0;
      rd_push.valid = mem_en_o & ~mem_we_o;
      rd_push.id    = owner_q;
   end

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (rd_push),
      .pop_o      (rd_pop),
      .nonempty_o (rd_nonempty)
   );

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (rd_pop.valid) begin
         rvalid_o[rd_pop.id] = 1'b1;
         rdata_o             = mem_rdata_i;
      end
   end

   assign busy_o = (state_q != IDLE) | rd_nonempty;

endmodule
